wb_burst_master: RTL

// - Wishbone B4 burst master that drives the SRAM slave's wishbone_* port, including cti/bte.
// - Turns one command (address, length, direction) into a single incrementing-burst cycle.
// - Streams write data in and read data out.
// - Sits directly upstream of the SRAM. It replaces the constant cti=000/bte=00 tie-off so the

---
 rtl/wb_pkg.sv | 9 +
 rtl/wb_burst_master.sv | 128 ++++++++++++
 2 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone B4 constants and the burst master state encoding.
package wb_pkg;
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  typedef enum logic [1:0] {IDLE, BURST, FIN} state_t;
endpackage

// File: rtl/wb_burst_master.sv
// Wishbone B4 incrementing-burst master: one command becomes one cyc with cti/bte,
// streaming write words in and read words out.
module wb_burst_master
  import wb_pkg::*;
#(
  parameter int ADR_W = 30,
  parameter int DAT_W = 32,
  parameter int LEN_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_we,
  input  logic [ADR_W-1:0]   cmd_adr,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic               wdat_valid,
  input  logic [DAT_W-1:0]   wdat,
  output logic               wdat_ready,
  output logic               rdat_valid,
  output logic [DAT_W-1:0]   rdat,
  output logic               rdat_last,
  output logic               done,
  output logic               done_err,
  output logic [ADR_W-1:0]   wishbone_adr,
  output logic [DAT_W-1:0]   wishbone_dat_w,
  input  logic [DAT_W-1:0]   wishbone_dat_r,
  output logic               wishbone_cyc,
  output logic               wishbone_stb,
  input  logic               wishbone_ack,
  output logic               wishbone_we,
  output logic [DAT_W/8-1:0] wishbone_sel,
  output logic [2:0]         wishbone_cti,
  output logic [1:0]         wishbone_bte,
  input  logic               wishbone_err
);

  state_t             r_state;
  logic               r_cmd_ready;
  logic               r_cyc;
  logic               r_we;
  logic [ADR_W-1:0]   r_adr;
  logic [LEN_W-1:0]   r_beats_left;
  logic               r_done;
  logic               r_done_err;

  logic               w_stb;
  logic               w_err;
  logic               w_beat;
  logic               w_last;

  // Writes only strobe when a data word is present; reads strobe every cycle of the burst.
  assign w_stb  = r_cyc & (r_we ? wdat_valid : 1'b1);
  assign w_err  = w_stb & wishbone_err;
  assign w_beat = w_stb & wishbone_ack & ~wishbone_err;
  assign w_last = (r_beats_left == '0);

  assign cmd_ready      = r_cmd_ready;
  assign wishbone_cyc   = r_cyc;
  assign wishbone_stb   = w_stb;
  assign wishbone_we    = r_we;
  assign wishbone_adr   = r_adr;
  assign wishbone_dat_w = wdat;
  assign wishbone_sel   = '1;
  assign wishbone_cti   = r_cyc ? (w_last ? CTI_EOB : CTI_INCR) : CTI_CLASSIC;
  assign wishbone_bte   = BTE_LINEAR;
  assign wdat_ready     = w_beat & r_we;
  assign rdat_valid     = w_beat & ~r_we;
  assign rdat           = wishbone_dat_r;
  assign rdat_last      = w_beat & ~r_we & w_last;
  assign done           = r_done;
  assign done_err       = r_done_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cmd_ready  <= 1'b1;
      r_cyc        <= 1'b0;
      r_we         <= 1'b0;
      r_adr        <= '0;
      r_beats_left <= '0;
      r_done       <= 1'b0;
      r_done_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_adr        <= cmd_adr;
            r_beats_left <= cmd_len;
            r_we         <= cmd_we;
            r_cyc        <= 1'b1;
            r_cmd_ready  <= 1'b0;
            r_state      <= BURST;
          end
        end
        BURST: begin
          if (w_err) begin
            r_cyc      <= 1'b0;
            r_done     <= 1'b1;
            r_done_err <= 1'b1;
            r_state    <= FIN;
          end else if (w_beat) begin
            r_adr <= r_adr + ADR_W'(1);
            if (w_last) begin
              r_cyc   <= 1'b0;
              r_done  <= 1'b1;
              r_state <= FIN;
            end else begin
              r_beats_left <= r_beats_left - LEN_W'(1);
            end
          end
        end
        FIN: begin
          r_done      <= 1'b0;
          r_done_err  <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_state     <= IDLE;
        end
        default: begin
          r_cyc       <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

endmodule
